mul_32b_seq: RTL and testbench

- Operand sequencer that sits directly upstream of mul_32b.
- Accepts 32-bit operand pairs from a producer through a valid/ready handshake and buffers them in a small FIFO.
- Issues one pair at a time to mul_32b with a single-cycle in_valid pulse, waits for out_valid, then captures the 64-bit product.
- Presents the product downstream through a registered valid/ready output.

---
 rtl/mul_32b_seq.sv | 149 ++++++++++++++
 tb/tb_mul_32b_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_32b_seq.sv
// mul_32b_seq: operand sequencer in front of mul_32b.
// Operand pairs are buffered in a small FIFO. Pairs go to the multiplier one at a time.
// Each product is held in a registered valid/ready result slot until the consumer takes it.
// Optional build macro MUL_SEQ_TIMEOUT_EN adds a WAIT watchdog.
// When it fires, the watchdog forces an all-ones product and pulses tmo_err.
module mul_32b_seq #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
`ifdef MUL_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TMO   = 255
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [N-1:0]   op_x,
  input  logic [N-1:0]   op_y,
  output logic [N-1:0]   mul_x,
  output logic [N-1:0]   mul_y,
  output logic           mul_in_valid,
  input  logic [2*N-1:0] mul_p,
  input  logic           mul_out_valid,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_p,
  output logic [N-1:0]   res_x,
  output logic [N-1:0]   res_y,
  output logic           busy
`ifdef MUL_SEQ_TIMEOUT_EN
  ,
  output logic           tmo_err
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q;
  logic [N-1:0]  fifo_x_q [DEPTH];
  logic [N-1:0]  fifo_y_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  logic          drain;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TW'(TMO - 1));
`endif

  // Handshake decode; issue is held off while an undrained result occupies the output slot
  assign op_ready = (count_q < (AW + 1)'(DEPTH));
  assign push     = op_valid && op_ready;
  assign drain    = res_valid && res_ready;
  assign pop      = (state_q == StIdle) && (count_q != '0) && (!res_valid || res_ready);
  assign busy     = (state_q != StIdle) || (count_q != '0) || res_valid;

  // FIFO storage: data needs no reset, only the pointers and count do
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x_q[wr_ptr_q] <= op_x;
      fifo_y_q[wr_ptr_q] <= op_y;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Issue/wait/capture FSM with registered multiplier and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      mul_x        <= '0;
      mul_y        <= '0;
      mul_in_valid <= 1'b0;
      res_valid    <= 1'b0;
      res_p        <= '0;
      res_x        <= '0;
      res_y        <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_err      <= 1'b0;
`endif
    end else begin
      // A drain clears the slot unless a capture below refills it on the same edge
      if (drain) res_valid <= 1'b0;
      mul_in_valid <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
      tmo_err      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            mul_x        <= fifo_x_q[rd_ptr_q];
            mul_y        <= fifo_y_q[rd_ptr_q];
            mul_in_valid <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          // Any out_valid seen here belongs to the previous operation
          state_q <= StWait;
`ifdef MUL_SEQ_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (mul_out_valid) begin
            res_p     <= mul_p;
            res_x     <= mul_x;
            res_y     <= mul_y;
            res_valid <= 1'b1;
            state_q   <= StIdle;
          end
`ifdef MUL_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            res_p     <= '1;
            res_x     <= mul_x;
            res_y     <= mul_y;
            res_valid <= 1'b1;
            tmo_err   <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_32b_seq.sv
// Bench for mul_32b_seq: behavioural mul_32b model with adjustable latency.
// A scoreboard queue checks every product handshake in order.
module tb_mul_32b_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_in_valid;
  logic [63:0] mul_p;
  logic        mul_out_valid;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_p;
  logic [31:0] res_x;
  logic [31:0] res_y;
  logic        busy;
`ifdef MUL_SEQ_TIMEOUT_EN
  logic        tmo_err;
`endif

  int errors = 0;
  int checks = 0;
  int n_issue = 0;
  int n_results = 0;
  int n_tmo = 0;
  logic [63:0]  last_p = '0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_e;

  always #5 clk = ~clk;

`ifdef MUL_SEQ_TIMEOUT_EN
  mul_32b_seq #(.N(32), .DEPTH(4), .AW(2), .TMO(10)) dut (
`else
  mul_32b_seq #(.N(32), .DEPTH(4), .AW(2)) dut (
`endif
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_x          (op_x),
    .op_y          (op_y),
    .mul_x         (mul_x),
    .mul_y         (mul_y),
    .mul_in_valid  (mul_in_valid),
    .mul_p         (mul_p),
    .mul_out_valid (mul_out_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_p         (res_p),
    .res_x         (res_x),
    .res_y         (res_y),
    .busy          (busy)
`ifdef MUL_SEQ_TIMEOUT_EN
    ,
    .tmo_err       (tmo_err)
`endif
  );

  // Multiplier model: out_valid pulses lat cycles after the in_valid edge
  int          lat = 3;
  int          mdl_cnt = 0;
  logic [63:0] mdl_p = '0;
  logic        mdl_mute = 1'b0;
  logic        stale_ov = 1'b0;

  always @(posedge clk) begin
    if (mul_in_valid) begin
      mdl_cnt <= lat;
      mdl_p   <= {32'b0, mul_x} * {32'b0, mul_y};
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  assign mul_out_valid = ((mdl_cnt == 1) && !mdl_mute) || stale_ov;
  assign mul_p         = mdl_p;

  // Scoreboard monitor, sampled just after the falling edge once inputs have settled
  always @(negedge clk) begin
    #1;
    if (mul_in_valid) n_issue++;
`ifdef MUL_SEQ_TIMEOUT_EN
    if (tmo_err) n_tmo++;
`endif
    if (rst && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got p=%h x=%h y=%h, required no result", res_p, res_x,
                 res_y);
      end else begin
        exp_e = exp_q.pop_front();
        if ({res_p, res_x, res_y} !== exp_e) begin
          errors++;
          $display("FAIL result_order: got p=%h x=%h y=%h, required p=%h x=%h y=%h", res_p,
                   res_x, res_y, exp_e[127:64], exp_e[63:32], exp_e[31:0]);
        end
      end
      last_p = res_p;
      n_results++;
    end
  end

  task automatic push_pair(input logic [31:0] x, input logic [31:0] y);
    int t;
    logic [63:0] p;
    t = 0;
    op_valid = 1'b1;
    op_x     = x;
    op_y     = y;
    while (!op_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!op_ready) begin
      errors++;
      $display("FAIL push_timeout: got op_ready=%b, required 1", op_ready);
    end
    p = {32'b0, x} * {32'b0, y};
    exp_q.push_back({p, x, y});
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < max; t++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mul_in_valid, mul_x, mul_y} !== 65'd0) begin
      errors++;
      $display("FAIL reset_mul: got in_valid=%b x=%h y=%h, required 0", mul_in_valid, mul_x, mul_y);
    end
    checks++;
    if ({res_valid, res_p, res_x, res_y} !== 129'd0) begin
      errors++;
      $display("FAIL reset_res: got valid=%b p=%h x=%h y=%h, required 0", res_valid, res_p, res_x,
               res_y);
    end
    checks++;
    if (busy !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b op_ready=%b, required busy=0 op_ready=1", busy,
               op_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n0;
    bit ok;
    n0 = n_issue;
    res_ready = 1'b1;
    push_pair(32'h3, 32'h5);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_idle: got busy=%b pending=%0d, required idle", busy, exp_q.size());
    end
    checks++;
    if (n_issue - n0 != 1) begin
      errors++;
      $display("FAIL single_pulses: got %0d in_valid pulses, required 1", n_issue - n0);
    end
    checks++;
    if (last_p !== 64'hF || res_x !== 32'h3 || res_y !== 32'h5) begin
      errors++;
      $display("FAIL single_value: got p=%h x=%h y=%h, required p=f x=3 y=5", last_p, res_x, res_y);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    bit ok;
    n0 = n_issue;
    lat = 8;
    res_ready = 1'b1;
    push_pair(32'h1, 32'h2);
    push_pair(32'h7, 32'h9);
    push_pair(32'hDEAD_BEEF, 32'h1234_5678);
    push_pair(32'h8000_0000, 32'h2);
    push_pair(32'h0001_0000, 32'h0001_0000);
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_op_ready: got op_ready=%b after 4 buffered+1 issued, required 0",
               op_ready);
    end
    push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_idle: got busy=%b pending=%0d, required idle", busy, exp_q.size());
    end
    checks++;
    if (last_p !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL fill_last: got p=%h, required fffffffe00000001", last_p);
    end
    checks++;
    if (n_issue - n0 != 6) begin
      errors++;
      $display("FAIL fill_pulses: got %0d in_valid pulses, required 6", n_issue - n0);
    end
    lat = 3;
  endtask

  task automatic test_backpressure();
    int n0;
    int t;
    bit ok;
    logic [63:0] p0;
    res_ready = 1'b0;
    push_pair(32'd11, 32'd13);
    push_pair(32'h0000_FFFF, 32'h0000_FFFF);
    push_pair(32'd5, 32'd0);
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL bp_first: got res_valid=%b, required 1", res_valid);
    end
    p0 = res_p;
    n0 = n_issue;
    repeat (20) @(negedge clk);
    checks++;
    if (res_p !== p0 || res_p !== 64'd143 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got p=%h valid=%b, required p=8f valid=1", res_p, res_valid);
    end
    checks++;
    if (n_issue != n0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_block: got %0d extra pulses busy=%b, required 0 extra busy=1",
               n_issue - n0, busy);
    end
    res_ready = 1'b1;
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: got busy=%b pending=%0d, required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_stale_out_valid();
    int t;
    int n0;
    bit ok;
    n0 = n_issue;
    res_ready = 1'b1;
    push_pair(32'd6, 32'd7);
    push_pair(32'd9, 32'd4);
    t = 0;
    while (!mul_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    stale_ov = 1'b1;
    t = 0;
    while (!mul_in_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!mul_in_valid) begin
      errors++;
      $display("FAIL stale_issue: got mul_in_valid=%b, required 1", mul_in_valid);
    end
    @(negedge clk);
    stale_ov = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (!ok || last_p !== 64'd36 || n_issue - n0 != 2) begin
      errors++;
      $display("FAIL stale_capture: got p=%h pulses=%0d idle=%b, required p=24 pulses=2 idle=1",
               last_p, n_issue - n0, ok);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n0;
    bit saw_rv;
    bit saw_ov;
    lat = 8;
    res_ready = 1'b1;
    push_pair(32'd21, 32'd2);
    push_pair(32'd22, 32'd3);
    push_pair(32'd23, 32'd4);
    push_pair(32'd24, 32'd5);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    checks++;
    if ({mul_in_valid, mul_x, mul_y, res_valid, res_p, busy} !== 131'd0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got in_valid=%b x=%h rv=%b p=%h busy=%b ready=%b, required 0/1",
               mul_in_valid, mul_x, res_valid, res_p, busy, op_ready);
    end
    n0 = n_issue;
    saw_rv = 1'b0;
    saw_ov = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid) saw_rv = 1'b1;
      if (mul_out_valid) saw_ov = 1'b1;
    end
    checks++;
    if (saw_rv || !saw_ov || n_issue != n0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late: got rv_seen=%b ov_seen=%b pulses=%0d busy=%b, required 0 1 0 0",
               saw_rv, saw_ov, n_issue - n0, busy);
    end
    lat = 3;
  endtask

`ifdef MUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    int n0;
    bit ok;
    n0 = n_tmo;
    mdl_mute = 1'b1;
    res_ready = 1'b1;
    push_pair(32'd2, 32'd3);
    exp_q[exp_q.size() - 1][127:64] = '1;
    t = 0;
    while (!mul_in_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!res_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 11) begin
      errors++;
      $display("FAIL tmo_latency: got res_valid %0d cycles after issue, required 11", t);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || last_p !== 64'hFFFF_FFFF_FFFF_FFFF || n_tmo - n0 != 1) begin
      errors++;
      $display("FAIL tmo_result: got p=%h tmo_pulses=%0d idle=%b, required all-ones 1 1", last_p,
               n_tmo - n0, ok);
    end
    mdl_mute = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b0;
    op_valid  = 1'b0;
    op_x      = '0;
    op_y      = '0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stale_out_valid();
    test_reset_mid_wait();
`ifdef MUL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
